// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared FSM encoding and sizing helpers for the sequential divider
package divisor_pkg;

  localparam int N_DIVIDENDO_DEF = 10;
  localparam int N_DIVISOR_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  // Counter must hold the full iteration count N_DIVIDENDO, hence the +1.
  function automatic int cnt_width(input int n_dividendo);
    return $clog2(n_dividendo + 1);
  endfunction

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/divisor_sequencial_if.sv
// rtl/divisor_sequencial_if.sv - start/done request and result bundle of the sequential divider
interface divisor_sequencial_if #(
  parameter int N_DIVIDENDO = 10,
  parameter int N_DIVISOR   = 5
);

  logic                   start;
  logic [N_DIVIDENDO-1:0] dividendo;
  logic [N_DIVISOR-1:0]   divisor;
  logic                   busy;
  logic                   done;
  logic [N_DIVIDENDO-1:0] quociente;
  logic [N_DIVISOR-1:0]   resto;
  logic                   div_zero;

  modport master (
    output start, dividendo, divisor,
    input  busy, done, quociente, resto, div_zero
  );

  modport slave (
    input  start, dividendo, divisor,
    output busy, done, quociente, resto, div_zero
  );

endinterface

// File: rtl/subtrator_restaurador.sv
// rtl/subtrator_restaurador.sv - W-bit ripple subtractor of full-subtractor cells; borrow=0 means a >= b
module subtrator_restaurador
  import divisor_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign o_diff[i]      = fs_diff(i_a[i], i_b[i], w_borrow[i]);
    assign w_borrow[i+1]  = fs_borrow(i_a[i], i_b[i], w_borrow[i]);
  end

  assign o_borrow = w_borrow[W];

endmodule

// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - restoring unsigned divider, one quotient bit per clock, start/done handshake
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int N_DIVIDENDO = N_DIVIDENDO_DEF,
  parameter int N_DIVISOR   = N_DIVISOR_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  divisor_sequencial_if.slave bus
);

  localparam int CW = cnt_width(N_DIVIDENDO);
  localparam int RW = N_DIVISOR + 1;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_busy;
  logic                   w_done;

  logic [N_DIVIDENDO-1:0] r_q;
  logic [N_DIVISOR-1:0]   r_d;
  logic [RW-1:0]          r_r;
  logic [CW-1:0]          r_cnt;

  logic [N_DIVIDENDO-1:0] r_quociente;
  logic [N_DIVISOR-1:0]   r_resto;
  logic                   r_div_zero;

  logic [RW-1:0]          w_t;
  logic [RW-1:0]          w_diff;
  logic                   w_borrow;
  logic [RW-1:0]          w_r_next;
  logic [N_DIVIDENDO-1:0] w_q_next;
  logic                   w_last;
  logic                   w_div_zero_in;
  logic                   w_unused_r_msb;

  // T shifts the next dividend bit into the partial remainder; R[MSB] never feeds T
  // because a restored remainder is always below D.
  assign w_t            = {r_r[N_DIVISOR-1:0], r_q[N_DIVIDENDO-1]};
  assign w_unused_r_msb = r_r[RW-1];

  subtrator_restaurador #(
    .W (RW)
  ) u_sub (
    .i_a      (w_t),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_r_next      = w_borrow ? w_t : w_diff;
  assign w_q_next      = {r_q[N_DIVIDENDO-2:0], ~w_borrow};
  assign w_last        = (r_cnt == CW'(1));
  assign w_div_zero_in = (bus.divisor == '0);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = w_div_zero_in ? FIM : CALC;
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = FIM;
        end
      end
      FIM: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quociente <= '0;
      r_resto     <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_q   <= bus.dividendo;
            r_d   <= bus.divisor;
            r_r   <= '0;
            r_cnt <= CW'(N_DIVIDENDO);
            // Divide by zero skips CALC, so its result is committed here on the way to FIM.
            if (w_div_zero_in) begin
              r_quociente <= '1;
              r_resto     <= '0;
              r_div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quociente <= w_q_next;
            r_resto     <= w_r_next[N_DIVISOR-1:0];
            r_div_zero  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.quociente = r_quociente;
  assign bus.resto     = r_resto;
  assign bus.div_zero  = r_div_zero;

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
- Sequential unsigned restoring divider.
- Inverse operation of the team's 5x5 array multiplier: it divides a product-width dividend by an operand-width divisor.
- Produces one quotient bit per clock using a shift/compare/subtract datapath built from full-subtractor cells.
- Sits between the switch/LED board I/O and the arithmetic blocks, with a start/done handshake.

Parameters:
- N_DIVIDENDO, 10, dividend width in bits; also the quotient width.
- N_DIVISOR, 5, divisor width in bits; also the remainder width.

Ports:
- CLOCK_50  in  1  single system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous reset, active-low; deassertion is synchronised externally.
- start  in  1  request pulse; sampled only in IDLE.
- dividendo  in  N_DIVIDENDO  dividend; captured on an accepted start.
- divisor  in  N_DIVISOR  divisor; captured on an accepted start.
- busy  out  1  high while in CALC or FIM.
- done  out  1  one-cycle pulse when results become valid.
- quociente  out  N_DIVIDENDO  quotient; held stable until the next accepted start.
- resto  out  N_DIVISOR  remainder; held stable until the next accepted start.
- div_zero  out  1  set when the captured divisor is 0; held with the results.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state goes to IDLE.
  - busy=0, done=0, quociente=0, resto=0, div_zero=0.
  - All internal registers are cleared.
- FSM states: IDLE, CALC, FIM.
- IDLE:
  - start=1 at edge t captures dividendo into shift register Q and divisor into D.
  - Partial remainder R (N_DIVISOR+1 bits) is cleared and counter cnt is set to N_DIVIDENDO.
  - busy goes high from t+1.
  - If divisor==0, go to FIM; otherwise go to CALC.
- CALC, one iteration per cycle:
  - Form T = {R[N_DIVISOR-1:0], Q[MSB]}.
  - If T >= {0,D}: R=T-D and shift 1 into Q[LSB].
  - Otherwise: R=T and shift 0 into Q[LSB].
  - cnt decrements each cycle; after the cycle in which cnt reaches 1, go to FIM.
- FIM:
  - done=1 for exactly this cycle; busy remains 1.
  - quociente/resto/div_zero are updated on the edge entering FIM, so they are valid while done=1.
  - Next state is IDLE.
- Latency:
  - Normal division: done is high in cycle t+N_DIVIDENDO+1, i.e. 11 cycles after the start edge with default parameters.
  - Divide by zero: done is high in cycle t+1.
- Divide by zero result: quociente = all ones, resto = 0, div_zero = 1.
- Remainder width: the final R is always < D, so resto = R[N_DIVISOR-1:0]. R[N_DIVISOR] exists only to hold the intermediate comparison.
- Output stability: quociente, resto and div_zero change only on entering FIM or on reset, never while in IDLE or CALC.
- start while busy=1: ignored; there is no queueing and the in-flight result is unaffected.
- start coincident with done (in FIM): ignored. The next request is accepted only in IDLE, so the minimum spacing between starts is latency+1 cycles.
- Inputs dividendo/divisor may change after the start edge without effect.
- Reset mid-operation: immediately aborts to IDLE with all outputs at 0, and no done pulse is produced.

Decomposition:
- Package divisor_pkg holds:
  - the FSM state encoding constants IDLE=2'd0, CALC=2'd1, FIM=2'd2;
  - a counter-width constant: $clog2(N_DIVIDENDO+1), evaluated per instance.
- One sub-module, subtrator_restaurador (parameter W):
  - a W-bit ripple subtractor built from full-subtractor cells;
  - outputs the difference and the final borrow;
  - borrow=0 means T >= D, which selects the restore/commit mux in CALC.
  - Instantiated with W=N_DIVISOR+1.

Test Plan:
- dividendo=100, divisor=7, start pulse -> done exactly 11 cycles after start; quociente=14, resto=2, div_zero=0.
- dividendo=1023, divisor=31 -> quociente=33, resto=0; also dividendo=1023, divisor=1 -> quociente=1023, resto=0.
- dividendo=5, divisor=9 -> quociente=0, resto=5; dividendo=0, divisor=3 -> quociente=0, resto=0.
- divisor=0, dividendo=77 -> done 1 cycle after start; quociente=1023, resto=0, div_zero=1; the next valid division clears div_zero.
- Start 100/7, then pulse start with 50/5 at cycles +3 and +11 (FIM) -> both ignored; result is 14 r 2, and the prior outputs stay unchanged through CALC.
- Start 100/7, drop reset_n at cycle +5 -> all outputs 0 and busy=0 immediately (asynchronous); no done pulse follows; a fresh 100/7 afterwards yields 14 r 2.
